// File: rtl/if_id_buffer_pkg.sv
// Shared definitions for the fetch/decode instruction buffer: default widths
// and the enable/stop signal levels used across the slice.
package if_id_buffer_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned DEF_INST_WIDTH = 32;
  localparam logic        EN             = 1'b1;
  localparam logic        STOP           = 1'b0;

endpackage

// File: rtl/if_id_buffer_fetch_compact.sv
// Fetch-group compaction: per lane, a write enable and a destination offset
// (prefix popcount of the valids), so valid lanes land contiguously from tail.
module if_id_buffer_fetch_compact
  import if_id_buffer_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned OFF_W       = 2
) (
  input  logic [FETCH_WIDTH-1:0]            i_valid,
  input  logic                              i_accept,
  output logic [FETCH_WIDTH-1:0]            o_wr_en,
  output logic [FETCH_WIDTH-1:0][OFF_W-1:0] o_offset,
  output logic [OFF_W-1:0]                  o_push_cnt
);

  logic [OFF_W-1:0] w_sum;

  // running prefix count gives each valid lane its slot relative to tail
  always_comb begin
    w_sum      = '0;
    o_wr_en    = '0;
    o_offset   = '0;
    for (int l = 0; l < int'(FETCH_WIDTH); l++) begin
      o_wr_en[l]  = (i_valid[l] == EN) & i_accept;
      o_offset[l] = w_sum;
      if (i_valid[l] == EN) begin
        w_sum = w_sum + OFF_W'(1);
      end else begin
        w_sum = w_sum;
      end
    end
    if (i_accept == EN) begin
      o_push_cnt = w_sum;
    end else begin
      o_push_cnt = '0;
    end
  end

endmodule

// File: rtl/if_id_buffer.sv
// Multi-lane instruction buffer between fetch and decode: DEPTH-entry circular
// queue, whole-group push, in-order prefix pop, single-cycle flush.
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH  = 2,
  parameter int unsigned DECODE_WIDTH = 2,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned INST_WIDTH   = DEF_INST_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [FETCH_WIDTH-1:0]             if_valid_i,
  input  logic [FETCH_WIDTH*ADDR_WIDTH-1:0]  if_pc_i,
  input  logic [FETCH_WIDTH*INST_WIDTH-1:0]  if_inst_i,
  output logic                               if_ready_o,
  output logic [DECODE_WIDTH-1:0]            id_valid_o,
  output logic [DECODE_WIDTH*ADDR_WIDTH-1:0] id_pc_o,
  output logic [DECODE_WIDTH*INST_WIDTH-1:0] id_inst_o,
  input  logic [DECODE_WIDTH-1:0]            id_ready_i,
  output logic [$clog2(DEPTH):0]             count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OFF_W = $clog2(FETCH_WIDTH + 1);
  localparam int unsigned POP_W = $clog2(DECODE_WIDTH + 1);

  logic [ADDR_WIDTH-1:0] r_pc_mem   [DEPTH];
  logic [INST_WIDTH-1:0] r_inst_mem [DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;

  logic [FETCH_WIDTH-1:0]            w_wr_en;
  logic [FETCH_WIDTH-1:0][OFF_W-1:0] w_offset;
  logic [OFF_W-1:0]                  w_push_cnt;
  logic [POP_W-1:0]                  w_pops;
  logic                              w_run;

  // ready depends only on registered occupancy, never on decode's ready
  assign if_ready_o = (CNT_W'(DEPTH) - r_count) >= CNT_W'(FETCH_WIDTH);
  assign count_o    = r_count;

  if_id_buffer_fetch_compact #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .OFF_W       (OFF_W)
  ) u_fetch_compact (
    .i_valid    (if_valid_i),
    .i_accept   (if_ready_o),
    .o_wr_en    (w_wr_en),
    .o_offset   (w_offset),
    .o_push_cnt (w_push_cnt)
  );

  // stored payload is not reset; valid is derived from count alone
  always_ff @(posedge clk) begin
    for (int l = 0; l < int'(FETCH_WIDTH); l++) begin
      if (w_wr_en[l] && !rst && !flush) begin
        r_pc_mem[r_tail + PTR_W'(w_offset[l])]   <= if_pc_i[l*ADDR_WIDTH +: ADDR_WIDTH];
        r_inst_mem[r_tail + PTR_W'(w_offset[l])] <= if_inst_i[l*INST_WIDTH +: INST_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_pops);
      r_tail  <= r_tail + PTR_W'(w_push_cnt);
      r_count <= r_count + CNT_W'(w_push_cnt) - CNT_W'(w_pops);
    end
  end

  // pops = leading run of valid&ready lanes; a ready beyond a gap is ignored
  always_comb begin
    w_pops = '0;
    w_run  = EN;
    for (int k = 0; k < int'(DECODE_WIDTH); k++) begin
      if (w_run == EN && id_valid_o[k] == EN && id_ready_i[k] == EN) begin
        w_pops = w_pops + POP_W'(1);
      end else begin
        w_run = STOP;
      end
    end
  end

  always_comb begin
    id_valid_o = '0;
    id_pc_o    = '0;
    id_inst_o  = '0;
    for (int k = 0; k < int'(DECODE_WIDTH); k++) begin
      if (r_count > CNT_W'(k)) begin
        id_valid_o[k]                          = EN;
        id_pc_o[k*ADDR_WIDTH +: ADDR_WIDTH]    = r_pc_mem[r_head + PTR_W'(k)];
        id_inst_o[k*INST_WIDTH +: INST_WIDTH]  = r_inst_mem[r_head + PTR_W'(k)];
      end else begin
        id_valid_o[k] = STOP;
      end
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: queue scoreboard of expected PCs,
// one task per scenario.
module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [1:0]  if_valid_i;
  logic [63:0] if_pc_i;
  logic [63:0] if_inst_i;
  logic        if_ready_o;
  logic [1:0]  id_valid_o;
  logic [63:0] id_pc_o;
  logic [63:0] id_inst_o;
  logic [1:0]  id_ready_i;
  logic [3:0]  count_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb_pc[$];

  if_id_buffer #(
    .FETCH_WIDTH(2), .DECODE_WIDTH(2), .DEPTH(8), .ADDR_WIDTH(32), .INST_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid_i(if_valid_i), .if_pc_i(if_pc_i), .if_inst_i(if_inst_i),
    .if_ready_o(if_ready_o),
    .id_valid_o(id_valid_o), .id_pc_o(id_pc_o), .id_inst_o(id_inst_o),
    .id_ready_i(id_ready_i), .count_o(count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_5A5A;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic [1:0] rdy);
    if_valid_i = v;
    if_pc_i    = {pc1, pc0};
    if_inst_i  = {inst_of(pc1), inst_of(pc0)};
    id_ready_i = rdy;
  endtask

  task automatic sb_push(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
    if (v[0]) sb_pc.push_back(pc0);
    if (v[1]) sb_pc.push_back(pc1);
  endtask

  task automatic test_drain();
    logic [1:0]  exp_v;
    logic [31:0] exp_pc;
    logic [31:0] got_pc;
    logic [31:0] got_inst;
    for (int it = 0; it < 8 && sb_pc.size() > 0; it++) begin
      drive(2'b00, 32'h0, 32'h0, 2'b11);
      exp_v = (sb_pc.size() >= 2) ? 2'b11 : 2'b01;
      n_checks++;
      if (id_valid_o !== exp_v) begin
        n_fail++;
        $display("FAIL drain_valid: got %b exp %b", id_valid_o, exp_v);
      end
      for (int k = 0; k < 2; k++) begin
        if (exp_v[k]) begin
          exp_pc   = sb_pc.pop_front();
          got_pc   = id_pc_o[k*32 +: 32];
          got_inst = id_inst_o[k*32 +: 32];
          n_checks++;
          if (got_pc !== exp_pc || got_inst !== inst_of(exp_pc)) begin
            n_fail++;
            $display("FAIL drain_lane%0d: got pc %h inst %h exp pc %h inst %h",
                     k, got_pc, got_inst, exp_pc, inst_of(exp_pc));
          end
        end
      end
      tick();
    end
    id_ready_i = 2'b00;
    n_checks++;
    if (count_o !== 4'd0 || sb_pc.size() != 0) begin
      n_fail++;
      $display("FAIL drain_empty: got count %0d left %0d exp 0", count_o, sb_pc.size());
      sb_pc.delete();
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    flush = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 2'b00);
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if (id_valid_o !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b exp 00", id_valid_o); end
    n_checks++;
    if (id_pc_o !== 64'd0 || id_inst_o !== 64'd0) begin
      n_fail++; $display("FAIL reset_data: got pc %h inst %h exp 0", id_pc_o, id_inst_o);
    end
    n_checks++;
    if (count_o !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", count_o); end
    n_checks++;
    if (if_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", if_ready_o); end
  endtask

  task automatic test_push_pair();
    drive(2'b11, 32'h1c00_0000, 32'h1c00_0004, 2'b00);
    n_checks++;
    if (if_ready_o !== 1'b1) begin n_fail++; $display("FAIL pair_ready: got %b exp 1", if_ready_o); end
    sb_push(2'b11, 32'h1c00_0000, 32'h1c00_0004);
    tick();
    drive(2'b00, 32'h0, 32'h0, 2'b00);
    n_checks++;
    if (count_o !== 4'd2) begin n_fail++; $display("FAIL pair_count: got %0d exp 2", count_o); end
    n_checks++;
    if (id_valid_o !== 2'b11) begin n_fail++; $display("FAIL pair_valid: got %b exp 11", id_valid_o); end
    n_checks++;
    if (id_pc_o !== {sb_pc[1], sb_pc[0]}) begin
      n_fail++; $display("FAIL pair_pc: got %h exp %h", id_pc_o, {sb_pc[1], sb_pc[0]});
    end
    test_drain();
  endtask

  task automatic test_fill();
    logic [31:0] base;
    logic [31:0] exp_pc;
    base = 32'h1c00_0100;
    for (int g = 0; g < 4; g++) begin
      drive(2'b11, base + 32'(8*g), base + 32'(8*g + 4), 2'b00);
      n_checks++;
      if (if_ready_o !== 1'b1) begin n_fail++; $display("FAIL fill_ready%0d: got %b exp 1", g, if_ready_o); end
      sb_push(2'b11, base + 32'(8*g), base + 32'(8*g + 4));
      tick();
    end
    drive(2'b11, base + 32'd32, base + 32'd36, 2'b00);
    n_checks++;
    if (count_o !== 4'd8) begin n_fail++; $display("FAIL fill_count: got %0d exp 8", count_o); end
    n_checks++;
    if (id_valid_o !== 2'b11) begin n_fail++; $display("FAIL fill_valid: got %b exp 11", id_valid_o); end
    for (int h = 0; h < 3; h++) begin
      n_checks++;
      if (if_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready%0d: got %b exp 0", h, if_ready_o); end
      tick();
      n_checks++;
      if (count_o !== 4'd8) begin n_fail++; $display("FAIL full_hold%0d: got %0d exp 8", h, count_o); end
    end
    id_ready_i = 2'b11;
    n_checks++;
    if (if_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_pop_ready: got %b exp 0", if_ready_o); end
    for (int k = 0; k < 2; k++) begin
      exp_pc = sb_pc.pop_front();
      n_checks++;
      if (id_pc_o[k*32 +: 32] !== exp_pc) begin
        n_fail++; $display("FAIL full_pop_lane%0d: got %h exp %h", k, id_pc_o[k*32 +: 32], exp_pc);
      end
    end
    tick();
    id_ready_i = 2'b00;
    n_checks++;
    if (count_o !== 4'd6) begin n_fail++; $display("FAIL after_pop_count: got %0d exp 6", count_o); end
    n_checks++;
    if (if_ready_o !== 1'b1) begin n_fail++; $display("FAIL after_pop_ready: got %b exp 1", if_ready_o); end
    sb_push(2'b11, base + 32'd32, base + 32'd36);
    tick();
    drive(2'b00, 32'h0, 32'h0, 2'b00);
    n_checks++;
    if (count_o !== 4'd8) begin n_fail++; $display("FAIL held_accept_count: got %0d exp 8", count_o); end
    test_drain();
  endtask

  task automatic test_sparse_prefix();
    drive(2'b10, 32'h1c00_0010, 32'h1c00_0014, 2'b00);
    sb_push(2'b10, 32'h1c00_0010, 32'h1c00_0014);
    tick();
    drive(2'b00, 32'h0, 32'h0, 2'b00);
    n_checks++;
    if (count_o !== 4'd1) begin n_fail++; $display("FAIL sparse_count: got %0d exp 1", count_o); end
    n_checks++;
    if (id_valid_o !== 2'b01) begin n_fail++; $display("FAIL sparse_valid: got %b exp 01", id_valid_o); end
    n_checks++;
    if (id_pc_o !== {32'h0, 32'h1c00_0014} || id_inst_o[63:32] !== 32'h0) begin
      n_fail++; $display("FAIL sparse_pc: got %h exp %h", id_pc_o, {32'h0, 32'h1c00_0014});
    end
    drive(2'b11, 32'h1c00_0018, 32'h1c00_001c, 2'b00);
    sb_push(2'b11, 32'h1c00_0018, 32'h1c00_001c);
    tick();
    drive(2'b00, 32'h0, 32'h0, 2'b10);
    n_checks++;
    if (id_valid_o !== 2'b11) begin n_fail++; $display("FAIL prefix_valid: got %b exp 11", id_valid_o); end
    tick();
    id_ready_i = 2'b00;
    n_checks++;
    if (count_o !== 4'd3) begin n_fail++; $display("FAIL prefix_count: got %0d exp 3", count_o); end
    n_checks++;
    if (id_pc_o[31:0] !== sb_pc[0]) begin
      n_fail++; $display("FAIL prefix_head: got %h exp %h", id_pc_o[31:0], sb_pc[0]);
    end
    test_drain();
  endtask

  task automatic test_flush();
    drive(2'b11, 32'h1c00_0200, 32'h1c00_0204, 2'b00);
    tick();
    drive(2'b11, 32'h1c00_0208, 32'h1c00_020c, 2'b00);
    tick();
    drive(2'b01, 32'h1c00_0210, 32'h1c00_0214, 2'b00);
    tick();
    n_checks++;
    if (count_o !== 4'd5) begin n_fail++; $display("FAIL preflush_count: got %0d exp 5", count_o); end
    drive(2'b11, 32'h1c00_0218, 32'h1c00_021c, 2'b11);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 2'b00);
    n_checks++;
    if (count_o !== 4'd0) begin n_fail++; $display("FAIL flush_count: got %0d exp 0", count_o); end
    n_checks++;
    if (id_valid_o !== 2'b00) begin n_fail++; $display("FAIL flush_valid: got %b exp 00", id_valid_o); end
    n_checks++;
    if (if_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b exp 1", if_ready_o); end
    drive(2'b11, 32'h1c00_0300, 32'h1c00_0304, 2'b00);
    sb_push(2'b11, 32'h1c00_0300, 32'h1c00_0304);
    tick();
    drive(2'b00, 32'h0, 32'h0, 2'b00);
    test_drain();
  endtask

  task automatic test_mid_reset();
    drive(2'b11, 32'h1c00_0400, 32'h1c00_0404, 2'b00);
    tick();
    drive(2'b00, 32'h0, 32'h0, 2'b00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (count_o !== 4'd0 || id_valid_o !== 2'b00 || id_pc_o !== 64'd0) begin
      n_fail++; $display("FAIL mid_reset: got count %0d valid %b pc %h exp 0", count_o, id_valid_o, id_pc_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] next_pc;
    logic [31:0] exp_pc;
    next_pc = 32'h1c00_1000;
    drive(2'b11, next_pc, next_pc + 32'd4, 2'b00);
    sb_push(2'b11, next_pc, next_pc + 32'd4);
    next_pc = next_pc + 32'd8;
    tick();
    for (int c = 0; c < 20; c++) begin
      drive(2'b11, next_pc, next_pc + 32'd4, 2'b11);
      n_checks++;
      if (count_o !== 4'd2 || id_valid_o !== 2'b11) begin
        n_fail++; $display("FAIL b2b_state%0d: got count %0d valid %b exp 2 11", c, count_o, id_valid_o);
      end
      for (int k = 0; k < 2; k++) begin
        exp_pc = sb_pc.pop_front();
        n_checks++;
        if (id_pc_o[k*32 +: 32] !== exp_pc) begin
          n_fail++; $display("FAIL b2b_pc%0d_%0d: got %h exp %h", c, k, id_pc_o[k*32 +: 32], exp_pc);
        end
      end
      sb_push(2'b11, next_pc, next_pc + 32'd4);
      next_pc = next_pc + 32'd8;
      tick();
    end
    drive(2'b00, 32'h0, 32'h0, 2'b00);
    test_drain();
  endtask

  initial begin
    test_reset();
    test_push_pair();
    test_fill();
    test_sparse_prefix();
    test_flush();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
